// File: rtl/pmips_mem_arbiter.sv
// pmips_mem_arbiter: shares one memory port between the instruction fetch
// stage and the data (load/store) stage. Conflicts alternate fairly, every
// access is bounded by a wait-cycle timeout, and a combinational stall
// holds the pipeline while either requester is waiting.
module pmips_mem_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] imemaddr,
    input  logic        imemreq,
    output logic [15:0] imemrdata,
    output logic        imemready,
    input  logic [15:0] dmemaddr,
    input  logic [15:0] dmemwdata,
    input  logic        dmemread,
    input  logic        dmemwrite,
    output logic [15:0] dmemrdata,
    output logic        dmemready,
    output logic        stall,
    output logic [15:0] memaddr,
    output logic [15:0] memwdata,
    output logic        memre,
    output logic        memwe,
    input  logic [15:0] memrdata,
    input  logic        memack,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } state_t;

    // Last wait-counter value before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_reg;
    logic        last_grant_reg;   // 0 = fetch was granted last, 1 = data
    logic [7:0]  wait_cnt_reg;
    logic        both_reg;         // load and store requested together
    logic        data_pending;

    assign data_pending = dmemread | dmemwrite;

    // Hold the pipeline while a requester is waiting and not being released.
    assign stall = (imemreq & ~imemready) | (data_pending & ~dmemready);

    // Arbitration FSM with registered memory strobes, ready pulses and read data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            wait_cnt_reg   <= 8'd0;
            both_reg       <= 1'b0;
            memaddr        <= 16'h0000;
            memwdata       <= 16'h0000;
            memre          <= 1'b0;
            memwe          <= 1'b0;
            imemready      <= 1'b0;
            dmemready      <= 1'b0;
            imemrdata      <= 16'h0000;
            dmemrdata      <= 16'h0000;
            timeout_err    <= 1'b0;
        end else begin
            imemready <= 1'b0;
            dmemready <= 1'b0;
            case (state_reg)
                IDLE: begin
                    // The ready cycle lets the requester drop its request
                    // before anything new is granted.
                    if (!imemready && !dmemready) begin
                        if (data_pending && (!imemreq || !last_grant_reg)) begin
                            state_reg      <= DACC;
                            last_grant_reg <= 1'b1;
                            wait_cnt_reg   <= 8'd0;
                            memaddr        <= dmemaddr;
                            memwdata       <= dmemwdata;
                            memwe          <= dmemwrite;
                            memre          <= ~dmemwrite;
                            both_reg       <= dmemread & dmemwrite;
                        end else if (imemreq) begin
                            state_reg      <= IACC;
                            last_grant_reg <= 1'b0;
                            wait_cnt_reg   <= 8'd0;
                            memaddr        <= imemaddr;
                            memwdata       <= 16'h0000;
                            memwe          <= 1'b0;
                            memre          <= 1'b1;
                            both_reg       <= 1'b0;
                        end
                    end
                end
                DACC: begin
                    if (memack) begin
                        memre     <= 1'b0;
                        memwe     <= 1'b0;
                        dmemready <= 1'b1;
                        state_reg <= IDLE;
                        // Pure stores leave the load data untouched.
                        if (memre) begin
                            dmemrdata <= memrdata;
                        end else if (both_reg) begin
                            dmemrdata <= 16'h0000;
                        end
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        memre       <= 1'b0;
                        memwe       <= 1'b0;
                        dmemready   <= 1'b1;
                        dmemrdata   <= 16'h0000;
                        timeout_err <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                IACC: begin
                    if (memack) begin
                        memre     <= 1'b0;
                        memwe     <= 1'b0;
                        imemready <= 1'b1;
                        imemrdata <= memrdata;
                        state_reg <= IDLE;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        memre       <= 1'b0;
                        memwe       <= 1'b0;
                        imemready   <= 1'b1;
                        imemrdata   <= 16'h0000;
                        timeout_err <= 1'b1;
                        state_reg   <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    memre     <= 1'b0;
                    memwe     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmips_mem_arbiter.sv
// tb_pmips_mem_arbiter: directed and randomized transactions against a
// transaction-level model of arbitration order, strobe duration, returned
// data and the sticky timeout flag.
module tb_pmips_mem_arbiter;

    localparam int TIMEOUT = 15;

    logic        clock;
    logic        reset;
    logic [15:0] imemaddr;
    logic        imemreq;
    logic [15:0] imemrdata;
    logic        imemready;
    logic [15:0] dmemaddr;
    logic [15:0] dmemwdata;
    logic        dmemread;
    logic        dmemwrite;
    logic [15:0] dmemrdata;
    logic        dmemready;
    logic        stall;
    logic [15:0] memaddr;
    logic [15:0] memwdata;
    logic        memre;
    logic        memwe;
    logic [15:0] memrdata;
    logic        memack;
    logic        timeout_err;

    int total = 0;
    int bad   = 0;

    // Reference model state: who won the last grant, last returned data, sticky error.
    bit          m_last_data;
    logic [15:0] m_irdata;
    logic [15:0] m_drdata;
    bit          m_terr;

    pmips_mem_arbiter #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .imemaddr    (imemaddr),
        .imemreq     (imemreq),
        .imemrdata   (imemrdata),
        .imemready   (imemready),
        .dmemaddr    (dmemaddr),
        .dmemwdata   (dmemwdata),
        .dmemread    (dmemread),
        .dmemwrite   (dmemwrite),
        .dmemrdata   (dmemrdata),
        .dmemready   (dmemready),
        .stall       (stall),
        .memaddr     (memaddr),
        .memwdata    (memwdata),
        .memre       (memre),
        .memwe       (memwe),
        .memrdata    (memrdata),
        .memack      (memack),
        .timeout_err (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        m_last_data = 1'b1;
        m_irdata    = 16'h0000;
        m_drdata    = 16'h0000;
        m_terr      = 1'b0;
    endtask

    // Acts as the memory for one access and checks it end to end.
    task automatic serve(input bit sd, input int lat, input logic [15:0] ea, input logic ewe,
                         input logic [15:0] ewd, input logic [15:0] rv, input logic [15:0] er,
                         input bit other, input bit drop);
        int n;
        int cyc;
        int exp_cyc;
        n = 0;
        while (!(memre | memwe) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("grant_lat", n, 1);
        if (!(memre | memwe)) return;
        cyc = 0;
        memrdata = rv;
        while ((memre | memwe) && cyc < 100) begin
            cyc++;
            chk("memaddr", memaddr, ea);
            chk("memwe", memwe, ewe);
            chk("memre", memre, !ewe);
            if (ewe) chk("memwdata", memwdata, ewd);
            if (cyc == 1 && !drop) chk("stall_busy", stall, 1);
            if (cyc == 1 && drop) begin
                if (sd) begin
                    dmemread  = 1'b0;
                    dmemwrite = 1'b0;
                    dmemaddr  = 16'($urandom);
                    dmemwdata = 16'($urandom);
                end else begin
                    imemreq  = 1'b0;
                    imemaddr = 16'($urandom);
                end
            end
            memack = (cyc == lat);
            @(negedge clock);
        end
        memack = 1'b0;
        exp_cyc = (lat < TIMEOUT) ? lat : TIMEOUT;
        chk("strobe_cycles", cyc, exp_cyc);
        if (sd) begin
            chk("dmemready", dmemready, 1);
            chk("imemready_idle", imemready, 0);
            chk("dmemrdata", dmemrdata, er);
            dmemread  = 1'b0;
            dmemwrite = 1'b0;
        end else begin
            chk("imemready", imemready, 1);
            chk("dmemready_idle", dmemready, 0);
            chk("imemrdata", imemrdata, er);
        end
        chk("stall_ready", stall, other);
        if (!sd) imemreq = 1'b0;
        @(negedge clock);
        chk("ready_pulse", imemready | dmemready, 0);
        chk("no_regrant", memre | memwe, 0);
    endtask

    // kind: 0 fetch, 1 load, 2 store, 3 load+store, 4 fetch+load, 5 fetch+store
    task automatic txn(input int kind, input int lat1, input int lat2, input bit drop,
                       input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd,
                       input logic [15:0] r1, input logic [15:0] r2);
        bit has_i;
        bit has_d;
        bit d_wr;
        bit d_rd;
        bit first_data;
        bit sd;
        bit to;
        int l;
        int nreq;
        logic [15:0] rv;
        logic [15:0] er;
        has_i = (kind == 0) || (kind >= 4);
        has_d = (kind != 0);
        d_wr  = (kind == 2) || (kind == 3) || (kind == 5);
        d_rd  = (kind == 1) || (kind == 3) || (kind == 4);
        imemreq   = has_i;
        imemaddr  = ia;
        dmemread  = d_rd;
        dmemwrite = d_wr;
        dmemaddr  = da;
        dmemwdata = wd;
        first_data = has_d && (!has_i || !m_last_data);
        nreq = (has_i && has_d) ? 2 : 1;
        $display("txn kind=%0d ia=%h da=%h wd=%h lat=%0d/%0d drop=%0d", kind, ia, da, wd, lat1, lat2, drop);
        for (int k = 0; k < nreq; k++) begin
            sd = (k == 0) ? first_data : !first_data;
            l  = (k == 0) ? lat1 : lat2;
            rv = (k == 0) ? r1 : r2;
            to = (l > TIMEOUT);
            if (sd) begin
                if (to) m_drdata = 16'h0000;
                else if (d_wr && d_rd) m_drdata = 16'h0000;
                else if (d_rd) m_drdata = rv;
                er = m_drdata;
            end else begin
                m_irdata = to ? 16'h0000 : rv;
                er = m_irdata;
            end
            m_terr = m_terr | to;
            m_last_data = sd;
            serve(sd, l, sd ? da : ia, sd ? d_wr : 1'b0, wd, rv, er, (k == 0) && (nreq == 2), drop);
            chk("timeout_err", timeout_err, m_terr);
        end
    endtask

    initial begin
        int kind;
        int lat;
        bit drop;
        int n;
        reset = 1'b1;
        imemreq = 0; imemaddr = 0; dmemread = 0; dmemwrite = 0;
        dmemaddr = 0; dmemwdata = 0; memrdata = 0; memack = 0;
        model_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_memre", memre, 0);
        chk("rst_memwe", memwe, 0);
        chk("rst_memaddr", memaddr, 0);
        chk("rst_memwdata", memwdata, 0);
        chk("rst_ready", {imemready, dmemready}, 0);
        chk("rst_imemrdata", imemrdata, 0);
        chk("rst_dmemrdata", dmemrdata, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_stall", stall, 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Conflict straight after reset: fetch wins, then load.
        txn(4, 1, 2, 0, 16'h0004, 16'h0100, 16'h0000, 16'h1111, 16'h2222);
        // Fetch only.
        txn(0, 1, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'h2A05, 16'h0000);
        chk("stall_after_fetch", stall, 0);
        // Store with a three-cycle memory.
        txn(2, 3, 1, 0, 16'h0000, 16'h0020, 16'hBEEF, 16'h7777, 16'h0000);
        // Load and store together behave as a store returning zero.
        txn(3, 2, 1, 0, 16'h0000, 16'h0030, 16'h1234, 16'h5555, 16'h0000);

        // Stray memack while idle changes nothing.
        memack = 1'b1;
        @(negedge clock);
        @(negedge clock);
        memack = 1'b0;
        chk("idle_ack_strobe", memre | memwe, 0);
        chk("idle_ack_ready", imemready | dmemready, 0);
        chk("idle_ack_drdata", dmemrdata, m_drdata);

        // Load that never completes.
        txn(1, 200, 1, 0, 16'h0000, 16'h0040, 16'h0000, 16'hCAFE, 16'h0000);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 5);
            lat  = $urandom_range(1, 6);
            if (kind <= 1 && $urandom_range(0, 7) == 0) lat = 20;
            drop = (kind <= 3) && ($urandom_range(0, 3) == 0);
            txn(kind, lat, $urandom_range(1, 4), drop, 16'($urandom), 16'($urandom),
                16'($urandom), 16'($urandom), 16'($urandom));
        end

        // Reset in the second cycle of a load, with memack asserted during reset.
        dmemread = 1'b1;
        dmemaddr = 16'h0456;
        n = 0;
        while (!memre && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("rst_load_grant", memre, 1);
        @(negedge clock);
        reset    = 1'b0;
        memack   = 1'b1;
        memrdata = 16'h9999;
        dmemread = 1'b0;
        #1;
        $display("txn mid-load reset");
        chk("mid_rst_memre", memre, 0);
        chk("mid_rst_memaddr", memaddr, 0);
        chk("mid_rst_imemrdata", imemrdata, 0);
        chk("mid_rst_dmemrdata", dmemrdata, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        @(negedge clock);
        reset  = 1'b1;
        memack = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("post_rst_ready", dmemready, 0);
            chk("post_rst_strobe", memre | memwe, 0);
        end

        txn(1, 2, 1, 0, 16'h0000, 16'h0050, 16'h0000, 16'h4321, 16'h0000);
        for (int i = 0; i < 10; i++) begin
            txn($urandom_range(0, 5), $urandom_range(1, 5), $urandom_range(1, 4), 0,
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pmips_mem_arbiter.md
PMIPS_MEM_ARBITER -- requirements
Module: pmips_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, 15, max cycles waiting for memack before abort (range 1..255).
REQ-002 Ports SHALL be, in order:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- imemaddr  in  16  fetch address from PC
- imemreq  in  1  fetch request
- imemrdata  out  16  fetched instruction
- imemready  out  1  one-cycle fetch-complete pulse
- dmemaddr  in  16  data address from EX/MEM
- dmemwdata  in  16  store data
- dmemread  in  1  load request
- dmemwrite  in  1  store request
- dmemrdata  out  16  load data
- dmemready  out  1  one-cycle data-complete pulse
- stall  out  1  pipeline hold
- memaddr  out  16  shared memory address
- memwdata  out  16  shared memory write data
- memre  out  1  shared memory read strobe
- memwe  out  1  shared memory write strobe
- memrdata  in  16  shared memory read data
- memack  in  1  shared memory completion
- timeout_err  out  1  sticky timeout flag
REQ-003 One clock domain; reset is asynchronous and active-low; no other reset source.

Function
REQ-004 FSM states SHALL be IDLE, DACC, IACC; all mem* outputs registered.
REQ-005 In IDLE, pending data request (dmemread|dmemwrite) and no fetch: go DACC; fetch only: go IACC; neither: stay IDLE.
REQ-006 Both pending in IDLE: grant opposite of last_grant bit (0=fetch, 1=data); last_grant reset value 1, so fetch wins first conflict; last_grant updated on every grant.
REQ-007 On grant, requester address/data/type SHALL be latched; memaddr/memwdata/memre/memwe driven from latch the cycle after grant and held constant until exit.
REQ-008 dmemread and dmemwrite both high: treated as write; dmemrdata returns 16'h0000.
REQ-009 In DACC/IACC, memack high: latch memrdata into dmemrdata (load) or imemrdata (fetch), deassert memre/memwe, pulse matching ready for exactly one cycle next cycle, return IDLE.
REQ-010 Store completion leaves dmemrdata unchanged.
REQ-011 Minimum latency: request sampled cycle N, strobe at N+1, memack at N+1, ready at N+2; no new grant in the ready cycle.
REQ-012 memack in IDLE SHALL be ignored.
REQ-013 Request deasserted while in flight: transaction completes, ready still pulsed.
REQ-014 Wait counter (8-bit) clears on grant, increments each DACC/IACC cycle without memack; reaching TIMEOUT_CYC: abort, deassert strobes, return 16'h0000 on the matching rdata, pulse matching ready, set timeout_err.
REQ-015 timeout_err SHALL remain 1 until reset.
REQ-016 stall = (imemreq & ~imemready) | ((dmemread|dmemwrite) & ~dmemready), combinational; low whenever no request pending.
REQ-017 imemrdata/dmemrdata SHALL hold last value between transactions.

Reset
REQ-018 reset low SHALL immediately force: state IDLE, memre=0, memwe=0, memaddr=0, memwdata=0, imemready=0, dmemready=0, imemrdata=0, dmemrdata=0, timeout_err=0, last_grant=1, wait counter 0.
REQ-019 Reset mid-transaction abandons it; no ready pulse issued for it after release.
REQ-020 First grant possible on first rising edge after reset deasserts.

Verification
REQ-021 Fetch only: imemaddr=16'h0010, memack one cycle after memre with memrdata=16'h2A05 -> memaddr=16'h0010, memre=1 one cycle, imemrdata=16'h2A05, imemready one pulse, stall low after pulse.
REQ-022 Simultaneous after reset: fetch 16'h0004 and load 16'h0100 -> fetch served first, then load; memaddr sequence 16'h0004 then 16'h0100; stall high until dmemready.
REQ-023 Store: dmemaddr=16'h0020, dmemwdata=16'hBEEF, memack after 3 cycles -> memwe=1 for 3 cycles with stable address/data, dmemready pulse, dmemrdata unchanged.
REQ-024 Timeout: load with memack never asserted, TIMEOUT_CYC=15 -> memre drops after 15 wait cycles, dmemrdata=16'h0000, dmemready pulse, timeout_err=1 stays high.
REQ-025 Reset mid-load: reset low in DACC cycle 2, memack during reset -> all outputs zero immediately, no dmemready after release, next request granted normally.
REQ-026 Read+write both high: dmemaddr=16'h0030 -> memwe=1, memre=0, dmemrdata=16'h0000.
